apb_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `apb_master` between `NUM_REQ` local requesters. It sits between on-chip clients and the user-side ports of `apb_master`. Each granted request is converted into a single APB transfer command, and a watchdog drives `TOUT_mst_i` for slow slaves. The result (read data and fail code) is returned to the owning requester with a one-cycle acknowledge.

---
 rtl/apb_master_arbiter.sv | 179 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one apb_master between NUM_REQ requesters.
// Each grant becomes one APB transfer; a watchdog raises TOUT for slow slaves.
module apb_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ERR_WIDTH   = 2,
  parameter int TOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NUM_REQ-1:0]               REQ_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR_i,
  input  logic [NUM_REQ-1:0]               REQ_RW_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA_i,
  output logic [NUM_REQ-1:0]               GNT_o,
  output logic [NUM_REQ-1:0]               ACK_o,
  output logic [DATA_WIDTH-1:0]            RDATA_o,
  output logic [ERR_WIDTH-1:0]             FAIL_o,
  output logic [ADDR_WIDTH-1:0]            ADDR_mst_o,
  output logic                             RW_mst_o,
  output logic                             TRANSFER_mst_o,
  output logic [DATA_WIDTH-1:0]            WDATA_mst_o,
  output logic                             TOUT_mst_o,
  input  logic                             DONE_mst_i,
  input  logic [ERR_WIDTH-1:0]             FAIL_mst_i,
  input  logic [DATA_WIDTH-1:0]            RDATA_mst_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TOUT_CYCLES + 2);
  localparam logic             TOUT_EN   = (TOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TOUT_MAX  = CNT_W'(TOUT_CYCLES);
  localparam logic [CNT_W-1:0] TOUT_LAST = (TOUT_CYCLES == 0) ? '0 : CNT_W'(TOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]     gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]     ack_reg, ack_next;
  logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;
  logic [ERR_WIDTH-1:0]   fail_reg, fail_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic                   rw_reg, rw_next;
  logic                   transfer_reg, transfer_next;
  logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
  logic                   tout_reg, tout_next;

  logic [ADDR_WIDTH-1:0]  req_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  req_wdata [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_addr[gi]  = REQ_ADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_wdata[gi] = REQ_WDATA_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First requester at or after ptr, wrapping around.
  logic             win_found;
  logic [PTR_W-1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found && REQ_i[(int'(ptr_reg) + off) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_reg) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    gnt_next      = gnt_reg;
    ack_next      = ack_reg;
    rdata_next    = rdata_reg;
    fail_next     = fail_reg;
    addr_next     = addr_reg;
    rw_next       = rw_reg;
    transfer_next = transfer_reg;
    wdata_next    = wdata_reg;
    tout_next     = tout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          addr_next     = req_addr[win_idx];
          rw_next       = REQ_RW_i[win_idx];
          wdata_next    = req_wdata[win_idx];
          gnt_next      = NUM_REQ'(1) << win_idx;
          transfer_next = 1'b1;
          ptr_next      = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
          cnt_next      = '0;
          state_next    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_reg != TOUT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
        // DONE takes priority over a timeout expiring on the same edge.
        if (DONE_mst_i) begin
          if (!rw_reg) begin
            rdata_next = RDATA_mst_i;
          end
          fail_next     = FAIL_mst_i;
          transfer_next = 1'b0;
          tout_next     = 1'b0;
          ack_next      = gnt_reg;
          state_next    = ST_RESP;
        end else if (TOUT_EN && cnt_reg == TOUT_LAST) begin
          tout_next = 1'b1;
        end
      end

      ST_RESP: begin
        ack_next   = '0;
        gnt_next   = '0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      gnt_reg      <= '0;
      ack_reg      <= '0;
      rdata_reg    <= '0;
      fail_reg     <= '0;
      addr_reg     <= '0;
      rw_reg       <= 1'b0;
      transfer_reg <= 1'b0;
      wdata_reg    <= '0;
      tout_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      gnt_reg      <= gnt_next;
      ack_reg      <= ack_next;
      rdata_reg    <= rdata_next;
      fail_reg     <= fail_next;
      addr_reg     <= addr_next;
      rw_reg       <= rw_next;
      transfer_reg <= transfer_next;
      wdata_reg    <= wdata_next;
      tout_reg     <= tout_next;
    end
  end

  assign GNT_o          = gnt_reg;
  assign ACK_o          = ack_reg;
  assign RDATA_o        = rdata_reg;
  assign FAIL_o         = fail_reg;
  assign ADDR_mst_o     = addr_reg;
  assign RW_mst_o       = rw_reg;
  assign TRANSFER_mst_o = transfer_reg;
  assign WDATA_mst_o    = wdata_reg;
  assign TOUT_mst_o     = tout_reg;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: the bench plays apb_master by driving
// DONE/FAIL/RDATA directly, with hand-computed expectations.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int TO = 8;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [N-1:0]      REQ_i;
  logic [N*AW-1:0]   REQ_ADDR_i;
  logic [N-1:0]      REQ_RW_i;
  logic [N*DW-1:0]   REQ_WDATA_i;
  logic [N-1:0]      GNT_o;
  logic [N-1:0]      ACK_o;
  logic [DW-1:0]     RDATA_o;
  logic [EW-1:0]     FAIL_o;
  logic [AW-1:0]     ADDR_mst_o;
  logic              RW_mst_o;
  logic              TRANSFER_mst_o;
  logic [DW-1:0]     WDATA_mst_o;
  logic              TOUT_mst_o;
  logic              DONE_mst_i;
  logic [EW-1:0]     FAIL_mst_i;
  logic [DW-1:0]     RDATA_mst_i;

  int checks   = 0;
  int failures = 0;

  apb_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW), .TOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ_i(REQ_i), .REQ_ADDR_i(REQ_ADDR_i), .REQ_RW_i(REQ_RW_i), .REQ_WDATA_i(REQ_WDATA_i),
    .GNT_o(GNT_o), .ACK_o(ACK_o), .RDATA_o(RDATA_o), .FAIL_o(FAIL_o),
    .ADDR_mst_o(ADDR_mst_o), .RW_mst_o(RW_mst_o), .TRANSFER_mst_o(TRANSFER_mst_o),
    .WDATA_mst_o(WDATA_mst_o), .TOUT_mst_o(TOUT_mst_o),
    .DONE_mst_i(DONE_mst_i), .FAIL_mst_i(FAIL_mst_i), .RDATA_mst_i(RDATA_mst_i)
  );

  always #5 PCLK = ~PCLK;

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] wd);
    REQ_ADDR_i[i*AW +: AW]  = a;
    REQ_RW_i[i]             = rw;
    REQ_WDATA_i[i*DW +: DW] = wd;
  endtask

  // One full transfer with REQ_i held: grant, DONE one cycle later, RESP.
  task automatic rr_xfer(input string tag, input logic [N-1:0] exp_gnt, input logic [AW-1:0] exp_addr);
    step();
    chk({tag, "_gnt"}, GNT_o, exp_gnt);
    chk({tag, "_addr"}, ADDR_mst_o, exp_addr);
    chk({tag, "_xfer"}, TRANSFER_mst_o, 1'b1);
    DONE_mst_i = 1'b1;
    step();
    DONE_mst_i = 1'b0;
    chk({tag, "_ack"}, ACK_o, exp_gnt);
    chk({tag, "_xfer_lo"}, TRANSFER_mst_o, 1'b0);
    step();
    chk({tag, "_resp_gnt"}, GNT_o, 4'b0000);
    chk({tag, "_resp_ack"}, ACK_o, 4'b0000);
    $display("rr %s grant=%b", tag, exp_gnt);
  endtask

  initial begin
    PRESETn     = 1'b0;
    REQ_i       = '0;
    REQ_ADDR_i  = '0;
    REQ_RW_i    = '0;
    REQ_WDATA_i = '0;
    DONE_mst_i  = 1'b0;
    FAIL_mst_i  = '0;
    RDATA_mst_i = '0;
    set_cmd(0, 32'h0000_0100, 1'b0, 32'h0000_0011);
    set_cmd(1, 32'h0000_0104, 1'b1, 32'h0000_0022);
    set_cmd(2, 32'h0000_0010, 1'b0, 32'h0000_0033);
    set_cmd(3, 32'h0000_010C, 1'b1, 32'h0000_0044);

    // Reset values
    step();
    step();
    PRESETn = 1'b1;
    chk("rst_gnt", GNT_o, 0);
    chk("rst_ack", ACK_o, 0);
    chk("rst_rdata", RDATA_o, 0);
    chk("rst_fail", FAIL_o, 0);
    chk("rst_addr", ADDR_mst_o, 0);
    chk("rst_rw", RW_mst_o, 0);
    chk("rst_xfer", TRANSFER_mst_o, 0);
    chk("rst_wdata", WDATA_mst_o, 0);
    chk("rst_tout", TOUT_mst_o, 0);
    $display("reset: outputs cleared");

    // Reset mid-WAIT: grant requester 1 (ptr->2), then reset
    REQ_i = 4'b0010;
    step();
    chk("mw_gnt", GNT_o, 4'b0010);
    chk("mw_addr", ADDR_mst_o, 32'h104);
    chk("mw_wdata", WDATA_mst_o, 32'h22);
    REQ_i = 4'b0000;
    step();
    step();
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    chk("mw_rst_gnt", GNT_o, 0);
    chk("mw_rst_xfer", TRANSFER_mst_o, 0);
    chk("mw_rst_addr", ADDR_mst_o, 0);
    chk("mw_rst_rw", RW_mst_o, 0);
    REQ_i = 4'b1111;
    step();
    chk("mw_ptr0_gnt", GNT_o, 4'b0001);
    REQ_i = 4'b0000;
    RDATA_mst_i = 32'hDEAD_0000;
    DONE_mst_i = 1'b1;
    step();
    DONE_mst_i = 1'b0;
    chk("mw_ack", ACK_o, 4'b0001);
    chk("mw_rdata", RDATA_o, 32'hDEAD_0000);
    step();
    $display("reset mid-WAIT: ptr restarted at 0");

    // Single read from requester 2 (ptr=1)
    REQ_i = 4'b0100;
    step();
    REQ_i = 4'b0000;
    chk("rd_gnt", GNT_o, 4'b0100);
    chk("rd_addr", ADDR_mst_o, 32'h10);
    chk("rd_rw", RW_mst_o, 1'b0);
    chk("rd_xfer", TRANSFER_mst_o, 1'b1);
    step();
    chk("rd_wait_ack", ACK_o, 0);
    RDATA_mst_i = 32'hA5A5_0001;
    FAIL_mst_i  = 2'b00;
    DONE_mst_i  = 1'b1;
    step();
    DONE_mst_i = 1'b0;
    chk("rd_ack", ACK_o, 4'b0100);
    chk("rd_rdata", RDATA_o, 32'hA5A5_0001);
    chk("rd_fail", FAIL_o, 0);
    chk("rd_xfer_lo", TRANSFER_mst_o, 1'b0);
    step();
    chk("rd_ack_lo", ACK_o, 0);
    chk("rd_gnt_lo", GNT_o, 0);
    step();
    chk("rd_gap_xfer", TRANSFER_mst_o, 1'b0);
    $display("single read: rdata=0x%0h", RDATA_o);

    // Write with error, REQ dropped after grant, fields changed after grant
    REQ_i = 4'b1000;
    step();
    REQ_i = 4'b0000;
    set_cmd(3, 32'h0000_FFFF, 1'b0, 32'h0000_0099);
    chk("wr_gnt", GNT_o, 4'b1000);
    chk("wr_rw", RW_mst_o, 1'b1);
    chk("wr_wdata", WDATA_mst_o, 32'h44);
    step();
    chk("wr_addr_frozen", ADDR_mst_o, 32'h10C);
    chk("wr_rw_frozen", RW_mst_o, 1'b1);
    RDATA_mst_i = 32'hBADB_AD00;
    FAIL_mst_i  = 2'b10;
    DONE_mst_i  = 1'b1;
    step();
    DONE_mst_i = 1'b0;
    FAIL_mst_i = 2'b00;
    chk("wr_ack", ACK_o, 4'b1000);
    chk("wr_fail", FAIL_o, 2'b10);
    chk("wr_rdata_kept", RDATA_o, 32'hA5A5_0001);
    step();
    set_cmd(3, 32'h0000_010C, 1'b1, 32'h0000_0044);
    $display("write error: fail=%0d", FAIL_o);

    // Round robin with ptr=0
    REQ_i = 4'b1111;
    rr_xfer("rr_a0", 4'b0001, 32'h100);
    rr_xfer("rr_a1", 4'b0010, 32'h104);
    rr_xfer("rr_a2", 4'b0100, 32'h010);
    rr_xfer("rr_a3", 4'b1000, 32'h10C);
    REQ_i = 4'b1001;
    rr_xfer("rr_b0", 4'b0001, 32'h100);
    rr_xfer("rr_b1", 4'b1000, 32'h10C);
    rr_xfer("rr_b2", 4'b0001, 32'h100);
    rr_xfer("rr_b3", 4'b1000, 32'h10C);
    REQ_i = 4'b0000;

    // Timeout: TRANSFER rises at edge k, TOUT at edge k+8
    REQ_i = 4'b0100;
    step();
    REQ_i = 4'b0000;
    chk("to_xfer", TRANSFER_mst_o, 1'b1);
    for (int c = 1; c < TO; c++) step();
    chk("to_before", TOUT_mst_o, 1'b0);
    step();
    chk("to_rise", TOUT_mst_o, 1'b1);
    step();
    step();
    chk("to_hold", TOUT_mst_o, 1'b1);
    chk("to_hold_xfer", TRANSFER_mst_o, 1'b1);
    RDATA_mst_i = 32'h1234_5678;
    FAIL_mst_i  = 2'b01;
    DONE_mst_i  = 1'b1;
    step();
    DONE_mst_i = 1'b0;
    FAIL_mst_i = 2'b00;
    chk("to_ack", ACK_o, 4'b0100);
    chk("to_fail", FAIL_o, 2'b01);
    chk("to_rdata", RDATA_o, 32'h1234_5678);
    chk("to_clear", TOUT_mst_o, 1'b0);
    step();
    $display("timeout: raised after %0d cycles", TO);

    // DONE on the same edge the timeout would fire: DONE wins
    REQ_i = 4'b0100;
    step();
    REQ_i = 4'b0000;
    chk("dw_gnt", GNT_o, 4'b0100);
    for (int c = 1; c < TO; c++) step();
    RDATA_mst_i = 32'h0000_BEEF;
    DONE_mst_i  = 1'b1;
    step();
    DONE_mst_i = 1'b0;
    chk("dw_ack", ACK_o, 4'b0100);
    chk("dw_tout", TOUT_mst_o, 1'b0);
    chk("dw_rdata", RDATA_o, 32'h0000_BEEF);
    step();
    $display("done-vs-timeout: ack without tout");

    // Spurious DONE in IDLE
    RDATA_mst_i = 32'hFFFF_FFFF;
    FAIL_mst_i  = 2'b11;
    DONE_mst_i  = 1'b1;
    step();
    step();
    DONE_mst_i = 1'b0;
    chk("sp_ack", ACK_o, 0);
    chk("sp_gnt", GNT_o, 0);
    chk("sp_xfer", TRANSFER_mst_o, 1'b0);
    chk("sp_rdata", RDATA_o, 32'h0000_BEEF);
    chk("sp_fail", FAIL_o, 2'b00);
    $display("spurious done: ignored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
